// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer: decodes phase/opcode/zero into datapath control strobes.
// Optional CTRL_SINGLE_STEP_EN adds a step input gating the exit from phase 0.
module cpu_controller #(
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            halt,
  output logic            inc_pc,
  output logic            ld_ac,
  output logic            ld_pc,
  output logic            wr,
  output logic            data_e,
  output logic [2:0]      phase
);

  localparam logic [OP_W-1:0] OpHlt = OP_W'(0);
  localparam logic [OP_W-1:0] OpSkz = OP_W'(1);
  localparam logic [OP_W-1:0] OpAdd = OP_W'(2);
  localparam logic [OP_W-1:0] OpAnd = OP_W'(3);
  localparam logic [OP_W-1:0] OpXor = OP_W'(4);
  localparam logic [OP_W-1:0] OpLda = OP_W'(5);
  localparam logic [OP_W-1:0] OpSto = OP_W'(6);
  localparam logic [OP_W-1:0] OpJmp = OP_W'(7);

  typedef enum logic [2:0] {
    InstAddr, InstFetch, InstLoad, Idle, OpAddr, OpFetch, AluOp, Store
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   advance;
  logic   aluop;

`ifdef CTRL_SINGLE_STEP_EN
  // A step pulse releases phase 0 only; the rest of the instruction runs on en.
  assign advance = en && ((phase_q != InstAddr) || step);
`else
  assign advance = en;
`endif

  assign aluop = (opcode == OpAdd) || (opcode == OpAnd) || (opcode == OpXor) ||
                 (opcode == OpLda);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= InstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q && advance) begin
      // HLT freezes in OpAddr instead of moving on.
      if (phase_q == OpAddr && opcode == OpHlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        InstAddr: begin
          sel = 1'b1;
        end
        InstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        InstLoad, Idle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        OpFetch: begin
          rd = aluop;
        end
        AluOp: begin
          rd     = aluop;
          inc_pc = (opcode == OpSkz) && zero;
          ld_pc  = (opcode == OpJmp);
          data_e = (opcode == OpSto);
        end
        Store: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OpJmp);
          wr     = (opcode == OpSto);
          data_e = (opcode == OpSto);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-cycle reference model plus directed phase-mask checks.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] phase;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_controller #(.OP_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
`ifdef CTRL_SINGLE_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .wr     (wr),
    .data_e (data_e),
    .phase  (phase)
  );

  // Reference model: phase counter and halted flag.
  int m_phase;
  bit m_halted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
    end else if (en && !m_halted) begin
`ifdef CTRL_SINGLE_STEP_EN
      if (m_phase != 0 || step) begin
`else
      begin
`endif
        if (m_phase == 4 && opcode == 3'd0) m_halted <= 1'b1;
        else m_phase <= (m_phase + 1) % 8;
      end
    end
  end

  // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}.
  function automatic logic [8:0] model_out(int ph, bit hlt, logic [2:0] op, logic z);
    bit alu, fetch, exec;
    logic [8:0] v;
    if (hlt) return 9'b000100000;
    alu   = (op >= 3'd2 && op <= 3'd5);
    fetch = (ph <= 3);
    exec  = (ph >= 5);
    v[8] = fetch;
    v[7] = (ph >= 1 && ph <= 3) || (exec && alu);
    v[6] = (ph == 2 || ph == 3);
    v[5] = (ph == 4 && op == 3'd0);
    v[4] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    v[3] = (ph == 7 && alu);
    v[2] = (ph >= 6 && op == 3'd7);
    v[1] = (ph == 7 && op == 3'd6);
    v[0] = (ph >= 6 && op == 3'd6);
    return v;
  endfunction

  always @(negedge clk) begin
    logic [8:0] exp_v, act_v;
    exp_v = model_out(m_phase, m_halted, opcode, zero);
    act_v = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
    checks++;
    if (act_v !== exp_v || phase !== 3'(m_phase)) begin
      errors++;
      $display("FAIL model t=%0t strobes=%b phase=%0d expected strobes=%b phase=%0d",
               $time, act_v, phase, exp_v, m_phase);
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  logic [7:0] m_rd, m_ldir, m_inc, m_ldac, m_ldpc, m_wr, m_de;

  // Runs one instruction from phase 0, recording each strobe as a per-phase bit mask.
  task automatic run_instr(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    en     = 1'b1;
    {m_rd, m_ldir, m_inc, m_ldac, m_ldpc, m_wr, m_de} = '0;
    for (int i = 0; i < 8; i++) begin
      m_rd[phase]   = rd;
      m_ldir[phase] = ld_ir;
      m_inc[phase]  = inc_pc;
      m_ldac[phase] = ld_ac;
      m_ldpc[phase] = ld_pc;
      m_wr[phase]   = wr;
      m_de[phase]   = data_e;
      cyc(1);
    end
    en = 1'b0;
    check("wrap_to_phase0", 9'(phase), 9'd0);
  endtask

  initial begin
    do_reset();
    check("reset_phase", 9'(phase), 9'd0);
    check("reset_strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
          9'b100000000);

    run_instr(3'd5, 1'b0);
    check("lda_rd", 9'(m_rd), 9'(8'b11101110));
    check("lda_ld_ir", 9'(m_ldir), 9'(8'b00001100));
    check("lda_inc_pc", 9'(m_inc), 9'(8'b00010000));
    check("lda_ld_ac", 9'(m_ldac), 9'(8'b10000000));

    run_instr(3'd1, 1'b1);
    check("skz_z1_inc_pc", 9'(m_inc), 9'(8'b01010000));
    check("skz_rd", 9'(m_rd), 9'(8'b00001110));
    run_instr(3'd1, 1'b0);
    check("skz_z0_inc_pc", 9'(m_inc), 9'(8'b00010000));

    run_instr(3'd6, 1'b0);
    check("sto_data_e", 9'(m_de), 9'(8'b11000000));
    check("sto_wr", 9'(m_wr), 9'(8'b10000000));
    check("sto_ld_ac", 9'(m_ldac), 9'd0);

    run_instr(3'd7, 1'b1);
    check("jmp_ld_pc", 9'(m_ldpc), 9'(8'b11000000));
    check("jmp_inc_pc", 9'(m_inc), 9'(8'b00010000));

    run_instr(3'd2, 1'b0);
    check("add_ld_ac", 9'(m_ldac), 9'(8'b10000000));

    // Stall in phase 2
    do_reset();
    en = 1'b1;
    cyc(2);
    en = 1'b0;
    cyc(3);
    check("stall_phase", 9'(phase), 9'd2);
    check("stall_ld_ir", 9'(ld_ir), 9'd1);
    en = 1'b1;
    cyc(1);
    check("resume_phase", 9'(phase), 9'd3);

    // Asynchronous reset in phase 5
    do_reset();
    opcode = 3'd5;
    en = 1'b1;
    cyc(5);
    check("pre_reset_phase", 9'(phase), 9'd5);
    rst = 1'b1;
    #1;
    check("mid_reset_phase", 9'(phase), 9'd0);
    check("mid_reset_strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
          9'b100000000);
    cyc(1);
    rst = 1'b0;
    en = 1'b0;

    // Halt
    do_reset();
    opcode = 3'd0;
    en = 1'b1;
    cyc(4);
    check("hlt_phase4", 9'(phase), 9'd4);
    check("hlt_strobes_p4", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
          9'b000110000);
    cyc(20);
    check("halted_phase", 9'(phase), 9'd4);
    check("halted_strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
          9'b000100000);
    opcode = 3'd5;
    cyc(2);
    check("halted_ignores_op", {9'(phase)}, 9'd4);
    rst = 1'b1;
    #1;
    check("halt_reset_phase", 9'(phase), 9'd0);
    check("halt_reset_halt", 9'(halt), 9'd0);
    cyc(1);
    rst = 1'b0;
    en = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
    do_reset();
    opcode = 3'd5;
    step = 1'b0;
    en = 1'b1;
    cyc(5);
    check("step_stuck_phase0", 9'(phase), 9'd0);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check("step_phase1", 9'(phase), 9'd1);
    cyc(7);
    check("step_back_phase0", 9'(phase), 9'd0);
    cyc(4);
    check("step_parked_phase0", 9'(phase), 9'd0);
    step = 1'b1;
    en = 1'b0;
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
